// File: rtl/death_anim_ctrl.sv
// ---------------------------------------------------------------------------
// death_anim_ctrl
//
// Sequences the player death animation over the death-sprite frame ROMs and
// produces the shared ROM read address for the pixel currently being drawn.
// Frames advance on vertical-refresh ticks: each frame is shown for
// HOLD_TICKS ticks, and after the last frame a one-cycle done pulse is
// produced. frame_sel and sprite_on are registered so that they line up with
// the ROMs' registered colour output, which appears one cycle after
// read_address.
//
// Ports:
//   Clk           pixel-rate clock
//   Reset         synchronous, active-high reset
//   start         one-cycle request to begin; only honoured in IDLE
//   frame_tick    one-cycle pulse per vertical refresh
//   pos_x, pos_y  sprite top-left corner, screen pixels
//   DrawX, DrawY  current pixel being drawn
//   read_address  address to all death frame ROMs (combinational)
//   frame_sel     frame index for the ROM output mux (registered)
//   sprite_on     ROM colour must be drawn this cycle (registered)
//   busy          high while the animation is playing
//   done          one-cycle pulse when the animation completes
//   fsm_state     current state (0 IDLE, 1 PLAY, 2 FIN) for observation
// ---------------------------------------------------------------------------
module death_anim_ctrl #(
    parameter int NUM_FRAMES = 5,
    parameter int HOLD_TICKS = 8,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [18:0] read_address,
    output logic [2:0]  frame_sel,
    output logic        sprite_on,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fsm_state
);

    localparam int TICK_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(HOLD_TICKS - 1);
    localparam logic [2:0]        FRAME_LAST = 3'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [2:0]        frame, frame_next;
    logic [TICK_W-1:0] tick_cnt, tick_next;

    // -----------------------------------------------------------------------
    // Hit test and address generation. The sprite's far edges are computed
    // in 11 bits so a sprite near the right/bottom edge clips instead of
    // wrapping around and producing false hits near X/Y = 0.
    // -----------------------------------------------------------------------
    logic [10:0] x_end, y_end;
    logic [9:0]  dx, dy;
    logic        hit;

    assign x_end = {1'b0, pos_x} + 11'(SPRITE_W);
    assign y_end = {1'b0, pos_y} + 11'(SPRITE_H);
    assign dx    = DrawX - pos_x;
    assign dy    = DrawY - pos_y;

    assign hit = (DrawX >= pos_x) && ({1'b0, DrawX} < x_end) &&
                 (DrawY >= pos_y) && ({1'b0, DrawY} < y_end);

    always_comb begin
        read_address = '0;
        if (hit) begin
            read_address = 19'(dy) * 19'(SPRITE_W) + 19'(dx);
        end
    end

    // -----------------------------------------------------------------------
    // Animation FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        frame_next = frame;
        tick_next  = tick_cnt;
        case (state)
            IDLE: begin
                // A tick arriving together with start is not counted.
                if (start) begin
                    state_next = PLAY;
                    frame_next = '0;
                    tick_next  = '0;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (tick_cnt < TICK_LAST) begin
                        tick_next = tick_cnt + 1'b1;
                    end else if (frame < FRAME_LAST) begin
                        frame_next = frame + 3'd1;
                        tick_next  = '0;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
                frame_next = '0;
                tick_next  = '0;
            end
            default: begin
                state_next = IDLE;
                frame_next = '0;
                tick_next  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and the output pipeline stage that matches ROM latency.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            frame     <= '0;
            tick_cnt  <= '0;
            frame_sel <= '0;
            sprite_on <= 1'b0;
        end else begin
            state     <= state_next;
            frame     <= frame_next;
            tick_cnt  <= tick_next;
            frame_sel <= frame;
            sprite_on <= hit && (state == PLAY);
        end
    end

    assign busy      = (state == PLAY);
    assign done      = (state == FIN);
    assign fsm_state = state;

endmodule

// File: tb/tb_death_anim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_death_anim_ctrl
//
// Directed bench for death_anim_ctrl. Drivers push expected values, stamped
// with the cycle at which they must be visible, into exp_q; a monitor on the
// falling clock edge pops and compares every entry due in that cycle. done
// pulses are tracked in a separate queue of expected cycles so that any
// unexpected pulse is also reported.
// ---------------------------------------------------------------------------
module tb_death_anim_ctrl;

    // -------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------
    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        frame_tick;
    logic [9:0]  pos_x, pos_y, DrawX, DrawY;
    logic [18:0] read_address;
    logic [2:0]  frame_sel;
    logic        sprite_on, busy, done;
    logic [1:0]  fsm_state;

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    death_anim_ctrl #(
        .NUM_FRAMES(5),
        .HOLD_TICKS(8),
        .SPRITE_W  (32),
        .SPRITE_H  (32)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .frame_tick  (frame_tick),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .read_address(read_address),
        .frame_sel   (frame_sel),
        .sprite_on   (sprite_on),
        .busy        (busy),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    // -------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------
    localparam int SIG_ADDR  = 0;
    localparam int SIG_SPR   = 1;
    localparam int SIG_FSEL  = 2;
    localparam int SIG_BUSY  = 3;
    localparam int SIG_DONE  = 4;
    localparam int SIG_STATE = 5;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  sig;
        logic [18:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_ADDR:  return "read_address";
            SIG_SPR:   return "sprite_on";
            SIG_FSEL:  return "frame_sel";
            SIG_BUSY:  return "busy";
            SIG_DONE:  return "done";
            default:   return "fsm_state";
        endcase
    endfunction

    function automatic logic [18:0] observe(input int sig);
        case (sig)
            SIG_ADDR:  return read_address;
            SIG_SPR:   return 19'(sprite_on);
            SIG_FSEL:  return 19'(frame_sel);
            SIG_BUSY:  return 19'(busy);
            SIG_DONE:  return 19'(done);
            default:   return 19'(fsm_state);
        endcase
    endfunction

    task automatic check(input string name, input logic [18:0] actual, input logic [18:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic expect_at(input int delta, input int sig, input logic [18:0] val);
        exp_t e;
        e.cyc = 32'(cyc + delta);
        e.sig = 4'(sig);
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Monitor: compare everything due this cycle, and police done.
    always @(negedge Clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (int'(exp_q[i].cyc) == cyc) begin
                check(sig_name(int'(exp_q[i].sig)), observe(int'(exp_q[i].sig)), exp_q[i].val);
                exp_q.delete(i);
            end
        end
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            check("done_pulse", 19'(done), 19'd1);
            void'(done_q.pop_front());
        end else if (done === 1'b1) begin
            check("done_unexpected", 19'(done), 19'd0);
        end
    end

    // -------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_pulse();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // One hit-test vector: address is combinational, sprite_on follows a cycle later.
    task automatic hit_vec(input logic [9:0] px, input logic [9:0] py,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic [18:0] exp_addr, input logic exp_spr);
        pos_x = px;
        pos_y = py;
        DrawX = x;
        DrawY = y;
        expect_at(0, SIG_ADDR, exp_addr);
        expect_at(1, SIG_SPR, 19'(exp_spr));
        step();
    endtask

    task automatic hit_tests();
        hit_vec(10'd100, 10'd200, 10'd131, 10'd231, 19'd1023, 1'b1);
        hit_vec(10'd100, 10'd200, 10'd132, 10'd231, 19'd0,    1'b0);
        hit_vec(10'd100, 10'd200, 10'd99,  10'd231, 19'd0,    1'b0);
        hit_vec(10'd100, 10'd200, 10'd100, 10'd200, 19'd0,    1'b1);
        hit_vec(10'd100, 10'd200, 10'd131, 10'd232, 19'd0,    1'b0);
        hit_vec(10'd100, 10'd200, 10'd105, 10'd202, 19'd69,   1'b1);
        hit_vec(10'd620, 10'd470, 10'd639, 10'd479, 19'd307,  1'b1);
        hit_vec(10'd620, 10'd470, 10'd0,   10'd479, 19'd0,    1'b0);
        hit_vec(10'd620, 10'd470, 10'd0,   10'd0,   19'd0,    1'b0);
        pos_x = 10'd100;
        pos_y = 10'd200;
        DrawX = 10'd0;
        DrawY = 10'd0;
    endtask

    // Issue ticks first_n..last_n (1-based count since start), one every
    // 'spacing' cycles. After tick n the expected frame is n/8; tick 40 ends it.
    task automatic play_ticks(input int first_n, input int last_n, input int spacing, input bit run_a);
        for (int n = first_n; n <= last_n; n++) begin
            int t0;
            t0 = cyc;
            if (n < 40) begin
                expect_at(1, SIG_BUSY, 19'd1);
                if (n % 8 == 0) begin
                    expect_at(1, SIG_FSEL, 19'(n / 8 - 1));
                    expect_at(2, SIG_FSEL, 19'(n / 8));
                end
            end else begin
                // Sprite in view on the last tick: drawn while still in PLAY,
                // suppressed once FIN has been entered.
                DrawX = 10'd110;
                DrawY = 10'd210;
                expect_at(1, SIG_SPR,   19'd1);
                expect_at(2, SIG_SPR,   19'd0);
                expect_at(1, SIG_STATE, 19'd2);
                expect_at(1, SIG_BUSY,  19'd0);
                expect_at(2, SIG_STATE, 19'd0);
                expect_at(2, SIG_BUSY,  19'd0);
                expect_at(2, SIG_DONE,  19'd0);
                done_q.push_back(cyc + 1);
            end
            tick_pulse();
            if (run_a && n == 1) hit_tests();
            if (run_a && n == 19) begin
                start = 1'b1;
                expect_at(1, SIG_BUSY, 19'd1);
                expect_at(1, SIG_STATE, 19'd1);
                step();
                start = 1'b0;
            end
            while (cyc < t0 + spacing) step();
            DrawX = 10'd0;
            DrawY = 10'd0;
        end
    endtask

    // -------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------
    initial begin
        Reset      = 1'b1;
        start      = 1'b1;
        frame_tick = 1'b0;
        pos_x      = 10'd100;
        pos_y      = 10'd200;
        DrawX      = 10'd0;
        DrawY      = 10'd0;
        repeat (3) step();
        Reset = 1'b0;
        start = 1'b0;
        expect_at(0, SIG_STATE, 19'd0);
        expect_at(0, SIG_BUSY,  19'd0);
        expect_at(0, SIG_SPR,   19'd0);
        expect_at(0, SIG_FSEL,  19'd0);
        expect_at(0, SIG_DONE,  19'd0);
        step();

        // Run A: 100-cycle tick spacing, hit tests, ignored restart at frame 2 tick 3.
        start = 1'b1;
        expect_at(0, SIG_BUSY, 19'd0);
        expect_at(1, SIG_BUSY, 19'd1);
        step();
        start = 1'b0;
        play_ticks(1, 40, 100, 1'b1);

        // Run B: start and frame_tick together in IDLE; that tick is not counted.
        start      = 1'b1;
        frame_tick = 1'b1;
        expect_at(1, SIG_BUSY,  19'd1);
        expect_at(1, SIG_STATE, 19'd1);
        step();
        start      = 1'b0;
        frame_tick = 1'b0;
        play_ticks(1, 40, 4, 1'b0);

        // Run C: reset in frame 3 with the sprite in view, then a clean replay.
        start = 1'b1;
        expect_at(1, SIG_BUSY, 19'd1);
        step();
        start = 1'b0;
        play_ticks(1, 26, 4, 1'b0);
        DrawX = 10'd110;
        DrawY = 10'd210;
        step();
        expect_at(0, SIG_SPR, 19'd1);
        expect_at(0, SIG_FSEL, 19'd3);
        Reset = 1'b1;
        expect_at(1, SIG_STATE, 19'd0);
        expect_at(1, SIG_BUSY,  19'd0);
        expect_at(1, SIG_SPR,   19'd0);
        expect_at(2, SIG_FSEL,  19'd0);
        expect_at(2, SIG_SPR,   19'd0);
        step();
        Reset = 1'b0;
        repeat (10) step();
        DrawX = 10'd0;
        DrawY = 10'd0;
        start = 1'b1;
        expect_at(1, SIG_BUSY, 19'd1);
        step();
        start = 1'b0;
        play_ticks(1, 40, 4, 1'b0);

        repeat (5) step();

        // -------------------------------------------------------------------
        // Final report
        // -------------------------------------------------------------------
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL %s never checked: due cycle %0d expected %0d", sig_name(int'(e.sig)), e.cyc, e.val);
        end
        while (done_q.size() > 0) begin
            int c;
            c = done_q.pop_front();
            n_checks++;
            $display("FAIL done_pulse missing: got none expected pulse at cycle %0d", c);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/death_anim_ctrl.md
Name: death_anim_ctrl

Overview:
- Sequences the player death animation across the death-sprite frame ROMs (frames 0..NUM_FRAMES-1, each a 32x32 ROM of 4-bit palette indices with a registered 24-bit colour output).
- Generates the shared 19-bit read address from the current VGA pixel and the sprite position.
- Advances frames on vertical-refresh ticks and drives the colour mux select and draw-enable, aligned to the ROMs' one-cycle read latency.
- Sits between the VGA pixel counter / game logic and the frame ROMs feeding the colour mapper.

Parameters:
- NUM_FRAMES, 5, number of death frames; frame indices are 0..NUM_FRAMES-1.
- HOLD_TICKS, 8, frame_tick pulses each frame is displayed; must be ≥1.
- SPRITE_W, 32, sprite width in pixels.
- SPRITE_H, 32, sprite height in pixels; SPRITE_W*SPRITE_H ≤ ROM depth (1024).

Ports:
- Clk  in  1  system clock (pixel-rate domain).
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin the animation; ignored unless in IDLE.
- frame_tick  in  1  one-cycle pulse per vertical refresh.
- pos_x  in  10  sprite top-left X, screen pixels.
- pos_y  in  10  sprite top-left Y, screen pixels.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- read_address  out  19  address to all death frame ROMs (combinational).
- frame_sel  out  3  frame index for the ROM data_Out mux; registered, aligned with ROM output.
- sprite_on  out  1  current ROM colour must be drawn; registered, aligned with ROM output.
- busy  out  1  high in PLAY.
- done  out  1  one-cycle pulse when the animation completes.

Behaviour:
- Reset: state=IDLE, frame=0, tick_cnt=0. Registered outputs frame_sel=0, sprite_on=0, done=0; busy=0.
- States:
  - IDLE: start=1 → PLAY, frame=0, tick_cnt=0.
  - PLAY, on frame_tick:
    - tick_cnt<HOLD_TICKS-1: tick_cnt+1.
    - else if frame<NUM_FRAMES-1: frame+1, tick_cnt=0.
    - else → FIN.
    - No frame_tick: hold.
  - FIN: done=1 for exactly this one cycle, → IDLE, frame=0.
- start outside IDLE is ignored; it neither restarts nor extends the animation. start and frame_tick in the same IDLE cycle: enter PLAY, tick not counted.
- Hit test uses 11-bit unsigned arithmetic so no wrap: DrawX≥pos_x, DrawX<pos_x+SPRITE_W, DrawY≥pos_y, DrawY<pos_y+SPRITE_H. A sprite extending past 639/479 simply clips.
- read_address = (DrawY-pos_y)*SPRITE_W + (DrawX-pos_x) when hit, else 0; zero-extended to 19 bits, combinational.
- Pipeline, registered each Clk: sprite_on ← hit AND state==PLAY; frame_sel ← current frame. Both are one cycle after read_address, matching ROM latency. In FIN and IDLE, sprite_on=0 from the following cycle.
- busy = (state==PLAY), combinational from the state register.
- Total animation length = NUM_FRAMES*HOLD_TICKS frame_ticks from start to the FIN entry, plus one cycle to the done pulse.
- Reset mid-PLAY: next cycle state=IDLE, frame=0, no done pulse, sprite_on=0.
- frame_tick in FIN: ignored.

Test Plan:
- Reset with start held high → after release, IDLE, busy=0, sprite_on=0, frame_sel=0, done=0; first start pulse → busy=1 next cycle.
- start, then 8 frame_ticks spaced 100 cycles apart → frame_sel=1 one cycle after the 8th tick's frame update; 40 ticks total → done high for exactly 1 cycle, busy=0 afterwards.
- PLAY, pos=(100,200), DrawX=131, DrawY=231 → read_address=1023, sprite_on=1 next cycle. DrawX=132 → read_address=0, sprite_on=0 next cycle. DrawX=99 → outside, sprite_on=0.
- pos=(620,470), DrawX=639, DrawY=479 → read_address=9*32+19=307, hit=1, no wrap false-hits at DrawX=0.
- start pulsed again at frame 2 tick 3 → sequence unchanged, done after the original 40 ticks; start and frame_tick coincident in IDLE → tick_cnt=0 in PLAY.
- Reset asserted at frame 3 → IDLE next cycle, done never pulses, frame_sel=0 one cycle later; new start replays from frame 0.
